vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Parametrised VGA/DVI raster timing generator, the next generation of the fixed 640x480 generator. Every timing field, both sync polarities, and the frame-counter width are parameters. Adds a soft restart, a frame counter, and one-cycle event pulses. All outputs are registered. It sits between the pixel-clock strobe source and the pixel pipeline, frame-buffer reader, and animation logic.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch in pixels (≥1)
H_SYNC, 96, horizontal sync width in pixels (≥1)
H_BP, 48, horizontal back porch in pixels (≥1)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch in lines (≥1)
V_SYNC, 2, vertical sync width in lines (≥1)
V_BP, 33, vertical back porch in lines (≥1)
HS_POL, 0, asserted level of o_hs (0 = active low)
VS_POL, 0, asserted level of o_vs (0 = active low)
FRAME_W, 16, width of the frame counter
Derived localparams: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; XW = clog2(H_ACTIVE); YW = clog2(V_ACTIVE).

Ports:
i_clk  in  1  base clock
i_rst_n  in  1  asynchronous active-low reset
i_pix_stb  in  1  pixel strobe; the raster advances one pixel per i_clk cycle with i_pix_stb=1
i_restart  in  1  synchronous soft restart to the pre-frame position
o_hs  out  1  horizontal sync at HS_POL level
o_vs  out  1  vertical sync at VS_POL level
o_de  out  1  data enable; high in the active region
o_x  out  XW  pixel column in active region, else 0
o_y  out  YW  pixel row in active region, else 0
o_line_start  out  1  one-cycle pulse on entering h=0 (every line, including blanking lines)
o_frame_start  out  1  one-cycle pulse on entering (h=0, v=0)
o_vblank_start  out  1  one-cycle pulse on entering (h=0, v=V_ACTIVE); this is the animate tick
o_frame  out  FRAME_W  frame count; increments on each frame start and wraps

Behaviour:
- Counters: h in 0..H_TOTAL-1; v in 0..V_TOTAL-1.
- Horizontal ordering: active, then FP, then sync, then BP. Vertical ordering is the same.
- Step rule: on each i_clk edge with i_pix_stb=1, h increments.
  - If h==H_TOTAL-1, h wraps to 0 and v increments.
  - If v==V_TOTAL-1 at that wrap, v wraps to 0.
- No strobe: all registered outputs hold, except the pulses, which clear on the next i_clk edge regardless of strobe. Every pulse is exactly one i_clk cycle wide.
- Registered decode: outputs are computed from the next counter value, so o_hs/o_vs/o_de/o_x/o_y always describe the same pixel as the internal counters. There is no skew between these outputs.
- Sync intervals:
  - o_hs asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - o_vs asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for the full lines.
- o_de = (h<H_ACTIVE) && (v<V_ACTIVE).
- o_x = h when h<H_ACTIVE, else 0. o_y = v when v<V_ACTIVE, else 0.
- Reset (async assert, sync deassert handled upstream):
  - Counters are set to the pre-frame position h=H_TOTAL-1, v=V_TOTAL-1.
  - o_de=0, o_x=0, o_y=0, all pulses 0, o_frame=0.
  - o_hs/o_vs at the deasserted level (~HS_POL, ~VS_POL).
  - The first strobe after reset enters (0,0): it fires o_line_start and o_frame_start, and sets o_frame=1.
- i_restart:
  - Acts on any i_clk edge, strobe not required, and has priority over i_pix_stb in the same cycle.
  - Loads the pre-frame position and outputs exactly as reset does, except that o_frame is kept.
  - Holding i_restart high freezes the generator at the pre-frame position.
  - Asserting it mid-line or mid-frame truncates that frame; no pulses fire for the truncated frame.
- o_frame wraps from 2^FRAME_W-1 to 0.
- Elaboration must fail if any porch or sync parameter is 0, or if H_ACTIVE or V_ACTIVE is below 2.

Decomposition:
- Shared package vga_timing_pkg:
  - Mode-preset constants for 640x480@60, 800x600@60 and 1280x720@60 (all eight timing fields plus polarities per mode).
  - The polarity encoding constants.
- Sub-module vga_axis_counter: a wrap counter with a terminal-count output and a synchronous preload.
  - Instantiated once for h (enabled by the strobe).
  - Instantiated once for v (enabled by the strobe AND h terminal count).

Test Plan:
- Defaults, strobe every clock, 2 frames after reset:
  - o_hs low exactly for h=656..751.
  - o_vs low for v=490..491.
  - o_de count per frame = 307200.
  - o_frame_start every 420000 clocks; o_frame = 1 then 2.
- Defaults, strobe every 4th clock:
  - All periods scale by 4.
  - Pulses stay 1 i_clk wide.
  - Outputs hold between strobes.
- Small mode (H 8/1/2/1, V 4/1/1/1, HS_POL=1, VS_POL=1):
  - Frame length 84 strobes.
  - o_hs high at h=9..10.
  - o_x sequence 0..7,0,0,0,0.
  - o_vblank_start at strobe 48 after frame start.
  - o_line_start 7 times per frame.
- i_restart at (h=100, v=200) coincident with a strobe:
  - Next cycle has o_de=0, o_x=0, o_y=0, and o_frame unchanged.
  - The next strobe fires o_frame_start.
- Async i_rst_n pulse mid-sync while the clock is stopped:
  - Outputs immediately go to reset values: o_hs high, o_frame=0.
- FRAME_W=2, run 5 frames:
  - o_frame sequence 1,2,3,0,1.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: sync polarity encodings and standard mode presets
// shared by the raster timing generator and its users.
package vga_timing_pkg;

  localparam logic POL_NEG = 1'b0;
  localparam logic POL_POS = 1'b1;

  typedef struct packed {
    int   h_active;
    int   h_fp;
    int   h_sync;
    int   h_bp;
    int   v_active;
    int   v_fp;
    int   v_sync;
    int   v_bp;
    logic hs_pol;
    logic vs_pol;
  } vga_mode_t;

  localparam vga_mode_t MODE_640X480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    hs_pol: POL_NEG, vs_pol: POL_NEG
  };

  localparam vga_mode_t MODE_800X600_60 = '{
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
    hs_pol: POL_POS, vs_pol: POL_POS
  };

  localparam vga_mode_t MODE_1280X720_60 = '{
    h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
    v_active: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20,
    hs_pol: POL_POS, vs_pol: POL_POS
  };

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: 0..MAX wrap counter, reset/preload to MAX.
// Ports: i_en step, i_load preload, o_cnt/o_nxt value, o_tc at MAX.
module vga_axis_counter #(
  parameter int MAX = 1,
  parameter int W   = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_load,
  output logic [W-1:0] o_cnt,
  output logic [W-1:0] o_nxt,
  output logic         o_tc
);

  localparam logic [W-1:0] LAST = W'(MAX);

  assign o_tc = (o_cnt == LAST);

  // Preload wins over stepping.
  always_comb begin
    o_nxt = o_cnt;
    if (i_load) begin
      o_nxt = LAST;
    end else if (i_en) begin
      o_nxt = o_tc ? '0 : o_cnt + W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt <= LAST;
    end else begin
      o_cnt <= o_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing with frame counter and
// event pulses. Ports: i_pix_stb, i_restart in; sync/de/x/y/pulses out.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = MODE_640X480_60.h_active,
  parameter int   H_FP     = MODE_640X480_60.h_fp,
  parameter int   H_SYNC   = MODE_640X480_60.h_sync,
  parameter int   H_BP     = MODE_640X480_60.h_bp,
  parameter int   V_ACTIVE = MODE_640X480_60.v_active,
  parameter int   V_FP     = MODE_640X480_60.v_fp,
  parameter int   V_SYNC   = MODE_640X480_60.v_sync,
  parameter int   V_BP     = MODE_640X480_60.v_bp,
  parameter logic HS_POL   = MODE_640X480_60.hs_pol,
  parameter logic VS_POL   = MODE_640X480_60.vs_pol,
  parameter int   FRAME_W  = 16,
  localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  XW       = $clog2(H_ACTIVE),
  localparam int  YW       = $clog2(V_ACTIVE)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_pix_stb,
  input  logic               i_restart,
  output logic               o_hs,
  output logic               o_vs,
  output logic               o_de,
  output logic [XW-1:0]      o_x,
  output logic [YW-1:0]      o_y,
  output logic               o_line_start,
  output logic               o_frame_start,
  output logic               o_vblank_start,
  output logic [FRAME_W-1:0] o_frame
);

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      H_ACTIVE < 2 || V_ACTIVE < 2) begin : g_bad_param
    $error("vga_timing_gen: illegal timing parameters");
  end

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_ACT = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_B  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_E  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ACT = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_B  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_E  = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic          h_tc, v_tc;

  vga_axis_counter #(
    .MAX (H_TOTAL - 1),
    .W   (HW)
  ) u_h (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_pix_stb),
    .i_load  (i_restart),
    .o_cnt   (h_cnt),
    .o_nxt   (h_nxt),
    .o_tc    (h_tc)
  );

  vga_axis_counter #(
    .MAX (V_TOTAL - 1),
    .W   (VW)
  ) u_v (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_pix_stb & h_tc),
    .i_load  (i_restart),
    .o_cnt   (v_cnt),
    .o_nxt   (v_nxt),
    .o_tc    (v_tc)
  );

  // Decode the position the counters are about to hold, so the
  // registered outputs line up with the counters without skew.
  logic          h_act, v_act;
  logic          hs_on, vs_on;
  logic          ls_nxt, fs_nxt, vb_nxt;
  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;

  assign h_act = (h_nxt < H_ACT);
  assign v_act = (v_nxt < V_ACT);
  assign hs_on = (h_nxt >= HS_B) && (h_nxt < HS_E);
  assign vs_on = (v_nxt >= VS_B) && (v_nxt < VS_E);
  assign x_nxt = h_act ? h_nxt[XW-1:0] : '0;
  assign y_nxt = v_act ? v_nxt[YW-1:0] : '0;

  // Pulses mark entry into h=0; a restart suppresses them.
  assign ls_nxt = i_pix_stb & ~i_restart & h_tc;
  assign fs_nxt = ls_nxt & v_tc;
  assign vb_nxt = ls_nxt & (v_cnt == V_LST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hs           <= ~HS_POL;
      o_vs           <= ~VS_POL;
      o_de           <= 1'b0;
      o_x            <= '0;
      o_y            <= '0;
      o_line_start   <= 1'b0;
      o_frame_start  <= 1'b0;
      o_vblank_start <= 1'b0;
    end else begin
      o_hs           <= hs_on ? HS_POL : ~HS_POL;
      o_vs           <= vs_on ? VS_POL : ~VS_POL;
      o_de           <= h_act & v_act;
      o_x            <= x_nxt;
      o_y            <= y_nxt;
      o_line_start   <= ls_nxt;
      o_frame_start  <= fs_nxt;
      o_vblank_start <= vb_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_frame <= '0;
    end else if (fs_nxt) begin
      o_frame <= o_frame + FRAME_W'(1);
    end
  end

endmodule
